// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: flow opcodes,
// FSM state encoding and ALU flag bit positions.
package pc_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_BRC  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } seq_state_t;

  // Bit positions within flags = {N,C,Z,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/return_stack.sv
// Small LIFO holding return addresses. The entry count doubles as the
// write pointer; top is the most recently pushed entry.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] ONE = LW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign top   = mem[AW'(level - ONE)];

  // Entry count: moves by one on an accepted push or pop.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + ONE;
    end else if (pop && !empty) begin
      level <= level - ONE;
    end
  end

  // Storage needs no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(level)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Control-flow sequencer in front of the Program_Counter. Decodes one flow
// command per cycle into wr_en/add_offset/counteradress and owns the
// CALL/RET return stack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | accepting commands; idle drive lets the counter increment
// ST_HALT  | pc held; resume=1 releases with one increment
// ST_FAULT | pc held at the fault vector until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] FAULT_VECTOR = 8'hF0,
  localparam int LW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_op,
  input  logic [PC_WIDTH-1:0] cmd_arg,
  input  logic [3:0]          cond_mask,
  input  logic [3:0]          flags,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                resume,
  output logic                cmd_ready,
  output logic                pc_wr_en,
  output logic                pc_add_offset,
  output logic [PC_WIDTH-1:0] pc_counteradress,
  output logic                halted,
  output logic                faulted,
  output logic [LW-1:0]       stack_level
);

  seq_state_t state, state_nxt;

  logic                push, pop;
  logic                stk_full, stk_empty;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] ret_addr;

  // Return address wraps naturally at the top of the address space.
  assign ret_addr = pc + PC_WIDTH'(1);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk       (clk),
    .res_n     (res_n),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .level     (stack_level)
  );

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy PC drive. Reset overrides everything so a command
  // presented during reset can neither move the counter nor touch the stack.
  always_comb begin
    state_nxt        = state;
    pc_wr_en         = 1'b0;
    pc_add_offset    = 1'b0;
    pc_counteradress = '0;
    push             = 1'b0;
    pop              = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_JMP: begin
              pc_wr_en         = 1'b1;
              pc_counteradress = cmd_arg;
            end
            OP_BR: begin
              pc_wr_en         = 1'b1;
              pc_add_offset    = 1'b1;
              pc_counteradress = cmd_arg;
            end
            OP_BRC: begin
              if (|(flags & cond_mask)) begin
                pc_wr_en         = 1'b1;
                pc_add_offset    = 1'b1;
                pc_counteradress = cmd_arg;
              end
            end
            OP_CALL: begin
              pc_wr_en = 1'b1;
              if (!stk_full) begin
                push             = 1'b1;
                pc_counteradress = cmd_arg;
              end else begin
                pc_counteradress = FAULT_VECTOR;
                state_nxt        = ST_FAULT;
              end
            end
            OP_RET: begin
              pc_wr_en = 1'b1;
              if (!stk_empty) begin
                pop              = 1'b1;
                pc_counteradress = stk_top;
              end else begin
                pc_counteradress = FAULT_VECTOR;
                state_nxt        = ST_FAULT;
              end
            end
            OP_HALT: begin
              pc_wr_en      = 1'b1;
              pc_add_offset = 1'b1;
              state_nxt     = ST_HALT;
            end
            default: ;  // NOP and reserved: let the counter increment
          endcase
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_RUN;
        end else begin
          pc_wr_en      = 1'b1;
          pc_add_offset = 1'b1;
        end
      end
      default: begin
        pc_wr_en      = 1'b1;
        pc_add_offset = 1'b1;
      end
    endcase

    if (!res_n) begin
      state_nxt        = ST_RUN;
      pc_wr_en         = 1'b0;
      pc_add_offset    = 1'b0;
      pc_counteradress = '0;
      push             = 1'b0;
      pop              = 1'b0;
    end
  end

  assign cmd_ready = (state == ST_RUN);
  assign halted    = (state == ST_HALT);
  assign faulted   = (state == ST_FAULT);

endmodule
